// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC result readout: FSM states, status-byte layout and frame sizing.
// Optional macro READOUT_PARITY_EN appends an XOR parity byte to every frame.
package tdc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_SEND  = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

  localparam logic [2:0] STATUS_MARKER = 3'b101;

  localparam int STATUS_OVF_BIT    = 7;
  localparam int STATUS_MARKER_LSB = 4;
  localparam int STATUS_SEQ_LSB    = 0;
  localparam int SEQ_W             = 4;
  localparam int STABLE_CNT_W      = 4;

  function automatic int value_bytes(input int width);
    return width / 8;
  endfunction

  // Status byte plus the value bytes, plus the parity byte when enabled.
  function automatic int frame_bytes(input int width);
`ifdef READOUT_PARITY_EN
    return value_bytes(width) + 2;
`else
    return value_bytes(width) + 1;
`endif
  endfunction

  function automatic logic [7:0] status_byte(input logic ovf, input logic [SEQ_W-1:0] seq);
    logic [7:0] b;
    b = 8'h00;
    b[STATUS_OVF_BIT]                      = ovf;
    b[STATUS_MARKER_LSB +: 3]              = STATUS_MARKER;
    b[STATUS_SEQ_LSB +: SEQ_W]             = seq;
    return b;
  endfunction

endpackage

// File: rtl/tdc_stop_detector.sv
// Watches the armed timer: flags a stop once the value has held for STABLE_CYCLES samples,
// and flags overflow immediately.
module tdc_stop_detector
  import tdc_pkg::*;
#(
  parameter int WIDTH         = 24,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             arm_i,
  input  logic             track_i,
  input  logic [WIDTH-1:0] timer_value_i,
  input  logic             timer_overflow_i,
  output logic             stop_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0]        prev_q, prev_d;
  logic [STABLE_CNT_W-1:0] cnt_q, cnt_d;
  logic                    same;

  assign same = (timer_value_i == prev_q);

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    if (arm_i) begin
      prev_d = timer_value_i;
      cnt_d  = '0;
    end else if (track_i) begin
      prev_d = timer_value_i;
      if (!same)            cnt_d = '0;
      else if (cnt_q != '1) cnt_d = cnt_q + STABLE_CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

  assign stop_o = track_i && same && (cnt_q == STABLE_CNT_W'(STABLE_CYCLES - 1));
  assign ovf_o  = track_i && timer_overflow_i;

endmodule

// File: rtl/tdc_result_readout.sv
// Captures a stopped/overflowed timer result, streams it as a byte frame over valid/ready,
// then pulses clear_out. Optional macro READOUT_PARITY_EN adds a trailing XOR parity byte.
module tdc_result_readout
  import tdc_pkg::*;
#(
  parameter int WIDTH         = 24,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step_set,
  input  logic [WIDTH-1:0] timer_value,
  input  logic             timer_overflow,
  output logic [7:0]       dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             clear_out,
  output logic             busy
);

  localparam int VALUE_BYTES = value_bytes(WIDTH);
  localparam int FRAME_N     = frame_bytes(WIDTH);
  localparam int IDX_W       = $clog2(FRAME_N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_N - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic               ovf_q, ovf_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_nxt;
  logic [7:0]         dout_q, dout_d;
  logic               valid_q, valid_d;
  logic [7:0]         next_byte;
  logic               stop_hit, ovf_hit;

  tdc_stop_detector #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_stop_detector (
    .clk              (clk),
    .reset_n          (reset_n),
    .arm_i            ((state_q == ST_IDLE) && step_set),
    .track_i          (state_q == ST_TRACK),
    .timer_value_i    (timer_value),
    .timer_overflow_i (timer_overflow),
    .stop_o           (stop_hit),
    .ovf_o            (ovf_hit)
  );

  assign idx_nxt = idx_q + IDX_W'(1);

`ifdef READOUT_PARITY_EN
  logic [7:0] parity;
  always_comb begin
    parity = status_byte(ovf_q, seq_q);
    for (int i = 0; i < VALUE_BYTES; i++) parity = parity ^ value_q[WIDTH-1-8*i -: 8];
  end
`endif

  // Byte to present after the current one transfers; value bytes go MSB first.
  always_comb begin
    next_byte = 8'h00;
    for (int i = 0; i < VALUE_BYTES; i++) begin
      if (idx_nxt == IDX_W'(i + 1)) next_byte = value_q[WIDTH-1-8*i -: 8];
    end
`ifdef READOUT_PARITY_EN
    if (idx_nxt == IDX_W'(VALUE_BYTES + 1)) next_byte = parity;
`endif
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    ovf_d   = ovf_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (step_set) state_d = ST_TRACK;
      end
      ST_TRACK: begin
        // Abort wins over capture; overflow wins over stop.
        if (!step_set) begin
          state_d = ST_IDLE;
        end else if (ovf_hit || stop_hit) begin
          state_d = ST_SEND;
          value_d = timer_value;
          ovf_d   = ovf_hit;
          idx_d   = '0;
          dout_d  = status_byte(ovf_hit, seq_q);
          valid_d = 1'b1;
        end
      end
      ST_SEND: begin
        if (valid_q && dout_ready) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            seq_d   = seq_q + SEQ_W'(1);
            state_d = ST_CLEAR;
          end else begin
            idx_d  = idx_nxt;
            dout_d = next_byte;
          end
        end
      end
      ST_CLEAR: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      value_q <= '0;
      ovf_q   <= 1'b0;
      seq_q   <= '0;
      idx_q   <= '0;
      dout_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      ovf_q   <= ovf_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign clear_out  = (state_q == ST_CLEAR);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tdc_result_readout.sv
// Directed bench for tdc_result_readout: stop, backpressure, abort, async reset, seq wrap, overflow.
// Build with READOUT_PARITY_EN defined to expect the trailing parity byte.
module tb_tdc_result_readout;

`ifdef READOUT_PARITY_EN
  localparam int FRAME_N = 5;
`else
  localparam int FRAME_N = 4;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        step_set;
  logic [23:0] timer_value;
  logic        timer_overflow;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        clear_out;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  tdc_result_readout #(.WIDTH(24), .STABLE_CYCLES(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .step_set       (step_set),
    .timer_value    (timer_value),
    .timer_overflow (timer_overflow),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .dout_ready     (dout_ready),
    .clear_out      (clear_out),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Consumes one frame, checking every byte, stall stability and the clear pulse.
  task automatic receive_frame(input string tag, input logic [7:0] st, input logic [23:0] val,
                               input bit bp);
    logic [7:0] exp_b [FRAME_N];
    int p;
    logic rdy;
    exp_b[0] = st;
    exp_b[1] = val[23:16];
    exp_b[2] = val[15:8];
    exp_b[3] = val[7:0];
`ifdef READOUT_PARITY_EN
    exp_b[4] = st ^ val[23:16] ^ val[15:8] ^ val[7:0];
`endif
    p = 0;
    for (int k = 0; k < FRAME_N; k++) begin
      check({tag, " byte"}, {22'd0, dout_valid, clear_out, dout}, {22'd0, 2'b10, exp_b[k]});
      do begin
        rdy = bp ? ((p % 3) == 0) : 1'b1;
        p++;
        dout_ready = rdy;
        step();
        if (!rdy) check({tag, " hold"}, {22'd0, dout_valid, clear_out, dout}, {22'd0, 2'b10, exp_b[k]});
      end while (!rdy);
    end
    dout_ready = 1'b0;
    check({tag, " clear pulse"}, {29'd0, dout_valid, clear_out, busy}, {29'd0, 3'b011});
    step();
    check({tag, " idle after"}, {29'd0, dout_valid, clear_out, busy}, {29'd0, 3'b000});
  endtask

  // Arms, holds the value (optionally with overflow), checks capture latency, then reads the frame.
  task automatic run_frame(input string tag, input logic [23:0] val, input logic ovf,
                           input logic [3:0] seq, input bit bp);
    int waited;
    waited = 0;
    step_set       = 1'b1;
    timer_value    = val;
    timer_overflow = 1'b0;
    step();
    timer_overflow = ovf;
    while (!dout_valid && waited < 8) begin
      step();
      waited++;
    end
    check({tag, " latency"}, 32'(waited), ovf ? 32'd1 : 32'd2);
    timer_overflow = 1'b0;
    step_set       = 1'b0;
    receive_frame(tag, {ovf, 3'b101, seq}, val, bp);
  endtask

  initial begin
    reset_n        = 1'b0;
    step_set       = 1'b0;
    timer_value    = '0;
    timer_overflow = 1'b0;
    dout_ready     = 1'b0;
    #12;
    check("reset outputs", {20'd0, dout, dout_valid, clear_out, busy, 1'b0},
          {20'd0, 8'h00, 4'b0000});
    reset_n = 1'b1;
    step();

    // Normal stop: counter ramps to 0x000123 and holds.
    step_set    = 1'b1;
    timer_value = 24'd0;
    step();
    check("armed busy", {31'd0, busy}, 32'd1);
    for (int v = 1; v <= 24'h000123; v++) begin
      timer_value = 24'(v);
      step();
    end
    check("ramp no valid", {31'd0, dout_valid}, 32'd0);
    step();
    check("one stable sample", {31'd0, dout_valid}, 32'd0);
    step();
    check("capture status", {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'h50});
    step_set = 1'b0;
    receive_frame("normal", 8'h50, 24'h000123, 1'b0);

    // Backpressure with ready pattern 1,0,0,1,...
    run_frame("backpressure", 24'h000123, 1'b0, 4'd1, 1'b1);

    // Abort in TRACK before the value settles.
    step_set    = 1'b1;
    timer_value = 24'h000005;
    step();
    check("abort tracking", {31'd0, busy}, 32'd1);
    timer_value = 24'h000006;
    step();
    step_set = 1'b0;
    step();
    check("abort idle", {29'd0, dout_valid, clear_out, busy}, 32'd0);
    step();
    check("abort no clear", {30'd0, dout_valid, clear_out}, 32'd0);

    // Async reset mid-frame; status 0x52 also shows abort kept seq.
    step_set    = 1'b1;
    timer_value = 24'h000777;
    step();
    step();
    step();
    check("prereset status", {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'h52});
    step_set   = 1'b0;
    dout_ready = 1'b1;
    step();
    check("prereset byte1", {23'd0, dout_valid, dout}, {23'd0, 1'b1, 8'h00});
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset drop", {29'd0, dout_valid, clear_out, busy}, 32'd0);
    check("async reset dout", {24'd0, dout}, 32'd0);
    #3;
    reset_n    = 1'b1;
    dout_ready = 1'b0;
    step();

    // Seventeen frames: seq 0..15 then wraps to 0.
    for (int i = 0; i < 17; i++) begin
      run_frame("wrap", 24'h0A0000 + 24'(i), 1'b0, 4'(i), 1'b0);
    end

    // Fresh reset, then overflow with value zero -> status 0xD0.
    #2;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    step();
    run_frame("overflow", 24'h000000, 1'b1, 4'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tdc_result_readout.md
Name: tdc_result_readout

Overview:
- Downstream consumer of the input timer stage.
- Watches the 24-bit timer value and the overflow flag while a measurement is armed, and detects when the count has stopped or overflowed.
- Captures the result and streams it out as a byte frame over a valid/ready handshake for the narrow output bus.
- After the frame completes, pulses a clear request back to the timer so the next measurement starts from zero.

Parameters:
- WIDTH, 24: timer value width. Must be a multiple of 8.
- STABLE_CYCLES, 2: consecutive unchanged samples (while armed) that count as "timer stopped". Range 1..15.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- step_set  input  1  measurement armed; same signal that enables the timer
- timer_value  input  WIDTH  timer count
- timer_overflow  input  1  timer overflow flag
- dout  output  8  frame byte
- dout_valid  output  1  dout holds a valid byte
- dout_ready  input  1  consumer accepts the byte
- clear_out  output  1  one-cycle clear pulse to the timer
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; sequence number 0; prev/stable registers 0. Reset is asynchronous, so dout_valid drops immediately even mid-frame.
- IDLE: when step_set=1, go to TRACK; prev <= timer_value; stable_cnt <= 0.
- TRACK, each cycle:
  - timer_value != prev: stable_cnt <= 0.
  - timer_value == prev: stable_cnt <= stable_cnt+1, saturating.
  - prev <= timer_value.
- Stop condition: timer_value == prev and stable_cnt == STABLE_CYCLES-1. On that edge, capture value = timer_value and ovf = 0, then go to SEND.
- Overflow condition: timer_overflow=1 in TRACK. On that edge, capture value = timer_value and ovf = 1, then go to SEND. Overflow has priority when both conditions occur in the same cycle.
- Abort: step_set=0 in TRACK returns to IDLE with no frame and no clear pulse. Abort has priority over capture.
- SEND:
  - dout_valid asserts the cycle after capture.
  - A byte transfers on a cycle with dout_valid & dout_ready.
  - dout and dout_valid are registered and held stable while dout_ready=0.
- Frame order:
  - byte0 = status: {ovf, 3'b101, seq[3:0]}.
  - Then the value, most significant byte first (WIDTH/8 bytes).
- Frame end:
  - After the last byte transfers: dout_valid=0, go to CLEAR, seq <= seq+1 (wraps 15->0).
  - step_set changes during SEND or CLEAR are ignored.
- CLEAR: clear_out=1 for exactly one cycle, then go to IDLE. The next measurement needs step_set sampled high in IDLE; if step_set is still high, it re-arms on the cycle after CLEAR.
- Throughput: with dout_ready tied high, the frame takes 1+WIDTH/8 cycles, plus 1 CLEAR cycle.

Optional Feature:
- Macro: READOUT_PARITY_EN.
- Defined: one extra trailing byte equal to the XOR of all preceding frame bytes, sent with the same handshake before CLEAR.
- Undefined: no parity byte; the frame ends after the value LSB byte.

Decomposition:
- Shared package tdc_pkg holds:
  - state encoding (IDLE, TRACK, SEND, CLEAR);
  - STATUS_MARKER = 3'b101;
  - byte-count constant derived from WIDTH;
  - status-byte field positions.
- Sub-module tdc_stop_detector holds the prev register, stable counter and stop/overflow decision.
- The top level holds the FSM, capture register, byte mux and handshake.

Test Plan:
- Normal stop: arm, counter runs 1..0x000123 then holds, ready=1 -> bytes 0x50,0x00,0x01,0x23 on consecutive cycles, then clear_out high for 1 cycle, busy low after.
- Backpressure: same stimulus, ready toggled 1,0,0,1,... -> every byte held stable while ready=0, no byte dropped or repeated.
- Overflow: force timer_overflow=1 with value 0x000000 in TRACK -> status byte 0xD0 (seq 0), value bytes 0x00,0x00,0x00.
- Abort: drop step_set in TRACK before stop -> no dout_valid, no clear_out, state IDLE, seq unchanged.
- Sequence wrap plus async reset: run 17 frames and check status seq goes 0..15,0. Assert reset_n=0 mid-frame -> dout_valid=0 immediately; seq=0 and stream restarts cleanly after release.
- READOUT_PARITY_EN defined: value 0x000123 -> extra byte 0x50^0x00^0x01^0x23 = 0x72 before clear_out.
